nx_msg_arbiter: RTL and testbench
=================================

NX_MSG_ARBITER -- requirements
Module: nx_msg_arbiter

Interface
REQ-001 SHALL have parameter STREAM_WIDTH, default 32, message width in bits.
REQ-002 SHALL have parameter REQUESTERS, default 3, number of outbound message sources; legal range 2..8.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is in this domain.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous, active-low (0 = reset).
REQ-005 SHALL have port req_data_i, input, REQUESTERS x STREAM_WIDTH, message data per requester.
REQ-006 SHALL have port req_dir_i, input, REQUESTERS x 2, target direction per requester.
REQ-007 SHALL have port req_valid_i, input, REQUESTERS, message present per requester.
REQ-008 SHALL have port req_ready_o, output, REQUESTERS, message accepted this cycle per requester.
REQ-009 SHALL have port out_data_o, output, 4 x STREAM_WIDTH, registered message per direction.
REQ-010 SHALL have port out_valid_o, output, 4, message present per direction.
REQ-011 SHALL have port out_ready_i, input, 4, downstream accepts per direction.
REQ-012 SHALL have port idle_o, output, 1, no message held and no request pending.

Function
REQ-013 SHALL encode directions as NORTH=0, EAST=1, SOUTH=2, WEST=3; each direction owns one output holding register.
REQ-014 SHALL treat a transfer as complete on any cycle where valid and ready are both high, on either side.
REQ-015 SHALL consider direction d open in a cycle when out_valid_o[d]=0, or when out_valid_o[d]=1 and out_ready_i[d]=1 (drain and refill in the same cycle).
REQ-016 SHALL consider requester r a candidate for d when req_valid_i[r]=1 and req_dir_i[r]=d; each requester is a candidate for exactly one direction.
REQ-017 SHALL, for each open direction with at least one candidate, grant exactly one candidate per the arbitration policy (REQ-030/031).
REQ-018 SHALL assert req_ready_o[r] combinationally in the grant cycle only; it is never high while req_valid_i[r]=0 or the direction is closed.
REQ-019 SHALL load the granted data into the holding register and set out_valid_o[d]=1 on the next clock edge; latency is 1 cycle.
REQ-020 SHALL clear out_valid_o[d] after a completed transfer with no new grant.
REQ-021 SHALL hold out_data_o[d] stable while out_valid_o[d]=1 and out_ready_i[d]=0.
REQ-022 SHALL arbitrate the four directions independently, allowing up to four grants per cycle.
REQ-023 SHALL drive idle_o=1 iff all out_valid_o are 0 and all req_valid_i are 0 (combinational).
REQ-024 SHALL, when a direction is closed, grant nothing for it and leave its pointer unchanged.
REQ-025 SHALL tolerate req_dir_i or req_data_i changing while req_valid_i=1 and not granted; the grant uses the values sampled in the grant cycle.

Reset
REQ-026 SHALL, while rst_i=0 at a clock edge, clear out_valid_o to 4'h0, out_data_o to all zeros, and every round-robin pointer to 0.
REQ-027 SHALL hold req_ready_o=0 during reset and discard held messages on reset mid-operation, with no completion reported.
REQ-028 SHALL evaluate idle_o with reset state values, so idle_o=1 whenever all req_valid_i=0.

Configuration
REQ-029 SHALL use macro NX_MSG_ARB_RR_EN to select the arbitration policy.
REQ-030 SHALL, with NX_MSG_ARB_RR_EN defined, use a per-direction round-robin: search candidates from pointer p upward, wrapping REQUESTERS-1 to 0; after a grant to r, p becomes (r+1) mod REQUESTERS.
REQ-031 SHALL, without NX_MSG_ARB_RR_EN, use fixed priority where the lowest index wins, with no pointer registers instantiated.

Structure
REQ-032 SHALL take direction constants (DIRX_NORTH..DIRX_WEST) from the shared nx package/constants; the module defines no local copies.
REQ-033 SHALL implement per-direction selection in one sub-module, nx_rr_arbiter (REQUESTERS-wide request in, one-hot grant out, pointer internal), instantiated four times in a generate loop.
REQ-034 SHALL be 120-400 lines of RTL in total.

Verification
REQ-035 SHALL cover: reset with all req_valid_i=1 -> req_ready_o=0, out_valid_o=0, idle_o=0; after release, grants begin the first cycle.
REQ-036 SHALL cover: RR, three requesters all dir=EAST, out_ready_i=4'hF -> grants in order 0,1,2,0,...; out_data_o[1] follows the same order 1 cycle later.
REQ-037 SHALL cover: out_ready_i[2]=0 with a held SOUTH message and requester 1 targeting SOUTH -> req_ready_o[1]=0 and data stable; raise ready -> drain and refill in the same cycle.
REQ-038 SHALL cover: requesters 0/1/2 targeting N/W/S simultaneously -> all three granted in one cycle, with valid on directions 0/3/2 next cycle.
REQ-039 SHALL cover: fixed priority (macro undefined), requesters 0 and 2 continuously on NORTH -> requester 2 is never granted while requester 0 is valid.
REQ-040 SHALL cover: rst_i=0 asserted with messages held -> out_valid_o=0 next cycle and the RR pointers restart at 0.

Source files
------------

// File: rtl/nx_msg_arbiter_pkg.sv
// Shared direction encoding and sizing constants for the nx message arbiter.
// Build option: define NX_MSG_ARB_RR_EN for round-robin selection (default is fixed priority).
package nx_msg_arbiter_pkg;

  typedef enum logic [1:0] {
    DIRX_NORTH = 2'd0,
    DIRX_EAST  = 2'd1,
    DIRX_SOUTH = 2'd2,
    DIRX_WEST  = 2'd3
  } dir_e;

  localparam int NUM_DIRS = 4;
  localparam int DIR_W    = 2;

  function automatic logic dir_hit(logic [DIR_W-1:0] dir, dir_e target);
    return dir_e'(dir) == target;
  endfunction

endpackage

// File: rtl/nx_msg_arbiter_rr_arbiter.sv
// Per-direction requester selection: one-hot grant out of an N-wide request vector.
// With NX_MSG_ARB_RR_EN the search starts at an internal pointer; otherwise lowest index wins.
module nx_rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

`ifdef NX_MSG_ARB_RR_EN
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next_ptr;
  logic          w_any;

  always_comb begin
    int idx;
    gnt_o      = '0;
    w_next_ptr = r_ptr;
    w_any      = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= N) idx = idx - N;
      if (en_i && !w_any && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        w_any      = 1'b1;
        w_next_ptr = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // Pointer only moves on an actual grant, so a closed direction keeps its place.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= w_next_ptr;
    end
  end
`else
  logic w_unused;
  logic w_any;

  assign w_unused = clk_i ^ rst_i;

  always_comb begin
    gnt_o = '0;
    w_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (en_i && !w_any && req_i[i]) begin
        gnt_o[i] = 1'b1;
        w_any    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/nx_msg_arbiter.sv
// Routes messages from REQUESTERS sources into four per-direction holding registers.
// Build option: NX_MSG_ARB_RR_EN selects round-robin instead of fixed-priority arbitration.
module nx_msg_arbiter
  import nx_msg_arbiter_pkg::*;
#(
  parameter int STREAM_WIDTH = 32,
  parameter int REQUESTERS   = 3
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [REQUESTERS*STREAM_WIDTH-1:0] req_data_i,
  input  logic [REQUESTERS*DIR_W-1:0]        req_dir_i,
  input  logic [REQUESTERS-1:0]              req_valid_i,
  output logic [REQUESTERS-1:0]              req_ready_o,
  output logic [NUM_DIRS*STREAM_WIDTH-1:0]   out_data_o,
  output logic [NUM_DIRS-1:0]                out_valid_o,
  input  logic [NUM_DIRS-1:0]                out_ready_i,
  output logic                               idle_o
);

  // Handshake: a transfer completes on any cycle where valid and ready are both high.
  logic [REQUESTERS-1:0]   w_cand [NUM_DIRS];
  logic [REQUESTERS-1:0]   w_gnt  [NUM_DIRS];
  logic [STREAM_WIDTH-1:0] w_sel  [NUM_DIRS];
  logic [NUM_DIRS-1:0]     w_open;
  logic [NUM_DIRS-1:0]     r_valid;
  logic [STREAM_WIDTH-1:0] r_data [NUM_DIRS];

  // A direction is open when empty or draining this cycle; reset closes all of them.
  always_comb begin
    for (int d = 0; d < NUM_DIRS; d++) begin
      w_cand[d] = '0;
      w_open[d] = rst_i && (!r_valid[d] || out_ready_i[d]);
      for (int r = 0; r < REQUESTERS; r++) begin
        w_cand[d][r] = req_valid_i[r] && dir_hit(req_dir_i[r*DIR_W +: DIR_W], dir_e'(DIR_W'(d)));
      end
    end
  end

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
    nx_rr_arbiter #(
      .N(REQUESTERS)
    ) u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (w_open[d]),
      .req_i (w_cand[d]),
      .gnt_o (w_gnt[d])
    );
  end

  always_comb begin
    req_ready_o = '0;
    for (int d = 0; d < NUM_DIRS; d++) begin
      req_ready_o = req_ready_o | w_gnt[d];
      w_sel[d]    = '0;
      for (int r = 0; r < REQUESTERS; r++) begin
        if (w_gnt[d][r]) w_sel[d] = w_sel[d] | req_data_i[r*STREAM_WIDTH +: STREAM_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_valid <= '0;
      for (int d = 0; d < NUM_DIRS; d++) r_data[d] <= '0;
    end else begin
      for (int d = 0; d < NUM_DIRS; d++) begin
        if (|w_gnt[d]) begin
          r_valid[d] <= 1'b1;
          r_data[d]  <= w_sel[d];
        end else if (out_ready_i[d]) begin
          r_valid[d] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int d = 0; d < NUM_DIRS; d++) out_data_o[d*STREAM_WIDTH +: STREAM_WIDTH] = r_data[d];
  end

  assign out_valid_o = r_valid;
  // During reset the holding registers count as already cleared.
  assign idle_o = ~|req_valid_i && (!rst_i || ~|r_valid);

endmodule

// File: tb/tb_nx_msg_arbiter.sv
// Directed bench for nx_msg_arbiter: vector table for uncontended routing plus
// hand-written sequences for reset, contention, back-pressure and pointer restart.
module tb_nx_msg_arbiter;
  localparam int SW = 32;
  localparam int RQ = 3;

  logic            clk_i;
  logic            rst_i;
  logic [RQ*SW-1:0] req_data_i;
  logic [RQ*2-1:0]  req_dir_i;
  logic [RQ-1:0]    req_valid_i;
  logic [RQ-1:0]    req_ready_o;
  logic [4*SW-1:0]  out_data_o;
  logic [3:0]       out_valid_o;
  logic [3:0]       out_ready_i;
  logic             idle_o;

  int total;
  int bad;
  logic [SW-1:0] exp_q[$];

  typedef struct {
    logic [2:0] valid;
    logic [5:0] dir;
    logic [3:0] ready;
    logic [2:0] exp_rdy;
    logic [3:0] exp_ov;
    logic [3:0] exp_hold;
  } vec_t;

  vec_t vecs[6];

  nx_msg_arbiter #(
    .STREAM_WIDTH(SW),
    .REQUESTERS(RQ)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_data_i  (req_data_i),
    .req_dir_i   (req_dir_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .idle_o      (idle_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [1:0] dir, input logic [31:0] data);
    req_valid_i[r]         = v;
    req_dir_i[r*2 +: 2]    = dir;
    req_data_i[r*SW +: SW] = data;
  endtask

  function automatic logic [31:0] dsel(input int d);
    return out_data_o[d*SW +: SW];
  endfunction

  function automatic logic [31:0] rr_data(input int r);
    return 32'hD000_0000 + 32'(r);
  endfunction

  initial begin
    int g;
    int g_prev;
    logic [31:0] exp_d;
    logic [31:0] q_val;
    total = 0;
    bad   = 0;

    vecs[0] = '{3'b001, 6'b00_00_00, 4'b1111, 3'b001, 4'b0001, 4'b0000};
    vecs[1] = '{3'b111, 6'b10_11_00, 4'b1111, 3'b111, 4'b1101, 4'b0000};
    vecs[2] = '{3'b110, 6'b00_01_00, 4'b0000, 3'b110, 4'b0011, 4'b0011};
    vecs[3] = '{3'b101, 6'b01_00_11, 4'b0101, 3'b101, 4'b1010, 4'b1010};
    vecs[4] = '{3'b000, 6'b00_00_00, 4'b1111, 3'b000, 4'b0000, 4'b0000};
    vecs[5] = '{3'b011, 6'b00_01_10, 4'b1010, 3'b011, 4'b0110, 4'b0100};

    // Reset with every requester pending on EAST.
    rst_i       = 1'b0;
    out_ready_i = 4'hF;
    req_valid_i = '0;
    req_dir_i   = '0;
    req_data_i  = '0;
    for (int r = 0; r < RQ; r++) set_req(r, 1'b1, 2'd1, rr_data(r));
    tick();
    tick();
    check("rst_ready", 32'(req_ready_o), 32'h0);
    check("rst_valid", 32'(out_valid_o), 32'h0);
    check("rst_idle", 32'(idle_o), 32'h0);
    check("rst_data_e", dsel(1), 32'h0);

    // First grant lands in the release cycle.
    rst_i = 1'b1;
    settle();
    check("release_grant", 32'(req_ready_o), 32'h1);
    exp_q.push_back(rr_data(0));

    for (int k = 1; k <= 6; k++) begin
      tick();
      q_val = exp_q.pop_front();
      check("east_data", dsel(1), q_val);
      check("east_valid", 32'(out_valid_o), 32'h2);
`ifdef NX_MSG_ARB_RR_EN
      g = k % 3;
`else
      g = 0;
`endif
      check("east_grant", 32'(req_ready_o), 32'(1 << g));
      exp_q.push_back(rr_data(g));
    end
    tick();
    q_val = exp_q.pop_front();
    check("east_data_last", dsel(1), q_val);
    req_valid_i = '0;
    tick();
    check("east_drained", 32'(out_valid_o), 32'h0);
    check("idle_after_east", 32'(idle_o), 32'h1);

    // Uncontended routing table: each direction has at most one candidate.
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < RQ; r++)
        set_req(r, vecs[i].valid[r], vecs[i].dir[r*2 +: 2], 32'h1000_0000 * 32'(i + 1) + 32'(r));
      out_ready_i = vecs[i].ready;
      settle();
      check("vec_ready", 32'(req_ready_o), 32'(vecs[i].exp_rdy));
      check("vec_idle", 32'(idle_o), 32'(vecs[i].valid == 3'b000));
      tick();
      check("vec_valid", 32'(out_valid_o), 32'(vecs[i].exp_ov));
      for (int r = 0; r < RQ; r++) begin
        if (vecs[i].valid[r]) begin
          exp_d = 32'h1000_0000 * 32'(i + 1) + 32'(r);
          check("vec_data", dsel(int'(vecs[i].dir[r*2 +: 2])), exp_d);
        end
      end
      req_valid_i = '0;
      tick();
      check("vec_hold", 32'(out_valid_o), 32'(vecs[i].exp_hold));
      out_ready_i = 4'hF;
      tick();
      check("vec_empty", 32'(out_valid_o), 32'h0);
    end

    // Back-pressure on SOUTH, then drain and refill in one cycle.
    set_req(0, 1'b1, 2'd2, 32'h5555_0000);
    out_ready_i = 4'b1011;
    settle();
    check("south_first_grant", 32'(req_ready_o), 32'h1);
    tick();
    check("south_held_valid", 32'(out_valid_o), 32'h4);
    check("south_held_data", dsel(2), 32'h5555_0000);
    set_req(0, 1'b0, 2'd0, 32'h0);
    set_req(1, 1'b1, 2'd2, 32'h6666_0001);
    settle();
    check("south_blocked", 32'(req_ready_o), 32'h0);
    tick();
    check("south_stable", dsel(2), 32'h5555_0000);
    check("south_stable_v", 32'(out_valid_o), 32'h4);
    set_req(1, 1'b1, 2'd2, 32'h6666_0002);
    settle();
    check("south_blocked2", 32'(req_ready_o), 32'h0);
    tick();
    out_ready_i = 4'hF;
    settle();
    check("south_refill_grant", 32'(req_ready_o), 32'h2);
    tick();
    check("south_refill_valid", 32'(out_valid_o), 32'h4);
    check("south_refill_data", dsel(2), 32'h6666_0002);
    req_valid_i = '0;
    tick();
    check("south_empty", 32'(out_valid_o), 32'h0);

    // Hold messages (moving the NORTH pointer), then reset mid-operation.
    set_req(1, 1'b1, 2'd0, 32'h7777_0001);
    set_req(2, 1'b1, 2'd1, 32'h7777_0002);
    out_ready_i = 4'h0;
    settle();
    check("pre_rst_grant", 32'(req_ready_o), 32'h6);
    tick();
    check("pre_rst_valid", 32'(out_valid_o), 32'h3);
    req_valid_i = '0;
    tick();
    check("pre_rst_hold", 32'(out_valid_o), 32'h3);
    rst_i = 1'b0;
    for (int r = 0; r < RQ; r++) set_req(r, 1'b1, 2'd0, 32'h0);
    settle();
    check("mid_rst_ready", 32'(req_ready_o), 32'h0);
    check("mid_rst_idle", 32'(idle_o), 32'h0);
    tick();
    check("mid_rst_valid", 32'(out_valid_o), 32'h0);
    check("mid_rst_data", dsel(0), 32'h0);
    req_valid_i = '0;
    settle();
    check("mid_rst_idle0", 32'(idle_o), 32'h1);

    // Contention on NORTH between requesters 0 and 2 right after reset.
    rst_i = 1'b1;
    out_ready_i = 4'hF;
    set_req(0, 1'b1, 2'd0, 32'h8888_0000);
    set_req(2, 1'b1, 2'd0, 32'h8888_0002);
    settle();
    g_prev = -1;
    for (int k = 0; k < 4; k++) begin
`ifdef NX_MSG_ARB_RR_EN
      g = (k % 2 == 1) ? 2 : 0;
`else
      g = 0;
`endif
      check("north_grant", 32'(req_ready_o), 32'(1 << g));
      if (g_prev >= 0) check("north_data", dsel(0), 32'h8888_0000 + 32'(g_prev));
      g_prev = g;
      tick();
    end
    check("north_data_last", dsel(0), 32'h8888_0000 + 32'(g_prev));
    req_valid_i = '0;
    tick();
    check("final_empty", 32'(out_valid_o), 32'h0);
    check("final_idle", 32'(idle_o), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
